// File: rtl/mmio_timer_multi_pkg.sv
// Shared register map, CTRL bit positions and reset constants for the multi-channel machine timer.
// Latency: none (declarations only); no backpressure.
package mmio_timer_multi_pkg;

    localparam int TMR_MTIME_LO   = 'h00;
    localparam int TMR_MTIME_HI   = 'h04;
    localparam int TMR_PRESC      = 'h08;
    localparam int TMR_CTRL       = 'h0C;
    localparam int TMR_CMP_BASE   = 'h10;
    localparam int TMR_CMP_STRIDE = 'h08;

    localparam int CTRL_EN_BIT = 0;
    localparam int CTRL_IE_LSB = 16;

    localparam logic [63:0] TMR_CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic int cmp_lo_off(input int idx);
        return TMR_CMP_BASE + idx * TMR_CMP_STRIDE;
    endfunction

endpackage

// File: rtl/mmio_timer_cmp_ch.sv
// One mtimecmp channel: register pair with its own write decode and a registered level irq.
// Latency: compare result registered, irq follows the condition by 1 clk; no backpressure.
module mmio_timer_cmp_ch
    import mmio_timer_multi_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int IDX    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [63:0]       mtime,
    input  logic              ie,
    output logic [63:0]       cmp,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] LO_ADDR = ADDR_W'(cmp_lo_off(IDX));
    localparam logic [ADDR_W-1:0] HI_ADDR = ADDR_W'(cmp_lo_off(IDX) + 4);

    logic [63:0] cmp_q, cmp_d;
    logic        irq_q, irq_d;

    always_comb begin
        cmp_d = cmp_q;
        if (wr_en && (waddr == LO_ADDR)) cmp_d[31:0]  = wdata;
        if (wr_en && (waddr == HI_ADDR)) cmp_d[63:32] = wdata;
        // Compare uses the current register values, so a cmp/ie change shows up one clk later.
        irq_d = ie & (mtime >= cmp_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp_q <= TMR_CMP_RST;
            irq_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            irq_q <= irq_d;
        end
    end

    assign cmp = cmp_q;
    assign irq = irq_q;

endmodule

// File: rtl/mmio_timer_multi.sv
// Memory-mapped 64-bit mtime with prescaler, global enable and NCMP compare channels with level irqs.
// Latency: reads return 1 clk after the strobe; no backpressure, a strobe is accepted every cycle.
module mmio_timer_multi
    import mmio_timer_multi_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NCMP    = 2,
    parameter int ADDR_W  = 8,
    parameter int PRESC_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata,
    output logic [NCMP-1:0]   timer_irq
);

    localparam logic [ADDR_W-1:0] A_MTIME_LO = ADDR_W'(TMR_MTIME_LO);
    localparam logic [ADDR_W-1:0] A_MTIME_HI = ADDR_W'(TMR_MTIME_HI);
    localparam logic [ADDR_W-1:0] A_PRESC    = ADDR_W'(TMR_PRESC);
    localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(TMR_CTRL);

    logic [63:0]        mtime_q, mtime_d;
    logic [31:0]        shadow_q, shadow_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic               ctrl_en_q, ctrl_en_d;
    logic [NCMP-1:0]    ie_q, ie_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;

    logic              wr_en, rd_en, tick;
    logic [ADDR_W-1:0] waddr;
    logic [63:0]       cmp_val [NCMP];
    logic              unused_addr_lsbs;

    assign waddr            = {addr[ADDR_W-1:2], 2'b00};
    assign unused_addr_lsbs = ^addr[1:0];
    assign wr_en            = sel & we;
    assign rd_en            = sel & ~we;
    assign tick             = ctrl_en_q && (pcnt_q == presc_q);

    always_comb begin
        mtime_d   = tick ? mtime_q + 64'd1 : mtime_q;
        pcnt_d    = pcnt_q;
        presc_d   = presc_q;
        ctrl_en_d = ctrl_en_q;
        ie_d      = ie_q;
        shadow_d  = shadow_q;
        rdata_d   = rdata_q;

        if (ctrl_en_q) pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);

        // A software write to either mtime half overrides that cycle's tick entirely.
        if (wr_en) begin
            case (waddr)
                A_MTIME_LO: mtime_d = {mtime_q[63:32], wdata};
                A_MTIME_HI: mtime_d = {wdata, mtime_q[31:0]};
                A_PRESC: begin
                    presc_d = wdata[PRESC_W-1:0];
                    pcnt_d  = '0;
                end
                A_CTRL: begin
                    ctrl_en_d = wdata[CTRL_EN_BIT];
                    ie_d      = wdata[CTRL_IE_LSB +: NCMP];
                end
                default: ;
            endcase
        end

        if (rd_en) begin
            rdata_d = '0;
            case (waddr)
                A_MTIME_LO: begin
                    rdata_d  = mtime_q[31:0];
                    shadow_d = mtime_q[63:32];
                end
                A_MTIME_HI: rdata_d = shadow_q;
                A_PRESC:    rdata_d[PRESC_W-1:0] = presc_q;
                A_CTRL: begin
                    rdata_d[CTRL_EN_BIT]          = ctrl_en_q;
                    rdata_d[CTRL_IE_LSB +: NCMP]  = ie_q;
                end
                default: ;
            endcase
            for (int i = 0; i < NCMP; i++) begin
                if (waddr == ADDR_W'(cmp_lo_off(i)))     rdata_d = cmp_val[i][31:0];
                if (waddr == ADDR_W'(cmp_lo_off(i) + 4)) rdata_d = cmp_val[i][63:32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime_q   <= '0;
            shadow_q  <= '0;
            presc_q   <= '0;
            pcnt_q    <= '0;
            ctrl_en_q <= 1'b0;
            ie_q      <= '0;
            rdata_q   <= '0;
        end else begin
            mtime_q   <= mtime_d;
            shadow_q  <= shadow_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            ctrl_en_q <= ctrl_en_d;
            ie_q      <= ie_d;
            rdata_q   <= rdata_d;
        end
    end

    for (genvar g = 0; g < NCMP; g++) begin : g_cmp
        mmio_timer_cmp_ch #(
            .ADDR_W (ADDR_W),
            .IDX    (g)
        ) u_cmp_ch (
            .clk   (clk),
            .reset (reset),
            .wr_en (wr_en),
            .waddr (waddr),
            .wdata (wdata),
            .mtime (mtime_q),
            .ie    (ie_q[g]),
            .cmp   (cmp_val[g]),
            .irq   (timer_irq[g])
        );
    end

    assign rdata = rdata_q;

endmodule

// File: doc/mmio_timer_multi.md
Name: mmio_timer_multi

Overview:
- Memory-mapped machine timer for the cpu6 SoC: one free-running 64-bit mtime and NCMP independent mtimecmp compare channels.
- Each channel drives its own level timer interrupt.
- Adds a programmable prescaler, a global enable, per-channel interrupt enables, and tear-free 64-bit reads of mtime over the 32-bit data bus.
- Sits on the core's data-memory port alongside the VGA/RAM decode.

Parameters:
- XLEN, 32, data bus width (fixed 32; 64-bit registers are split lo/hi).
- NCMP, 2, number of compare channels (1..16).
- ADDR_W, 8, byte-address width of the register window.
- PRESC_W, 8, prescaler width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- sel  in  1  bus access strobe for this block
- we  in  1  1 = write, 0 = read (qualified by sel)
- addr  in  ADDR_W  byte address, word aligned (addr[1:0] ignored)
- wdata  in  XLEN  write data
- rdata  out  XLEN  read data, valid the cycle after a read strobe
- timer_irq  out  NCMP  per-channel level interrupt

Behaviour:
- Register map (word offsets):
  - 0x00 MTIME_LO; 0x04 MTIME_HI (returns the shadow captured at the last MTIME_LO read).
  - 0x08 PRESC[PRESC_W-1:0].
  - 0x0C CTRL: bit0 = global count enable, bits[16+i] = irq enable for channel i.
  - 0x10+8i MTIMECMP_LO[i]; 0x14+8i MTIMECMP_HI[i].
- Unmapped addresses read 0; writes to them are ignored.
- Reset values (asserted asynchronously while reset = 0):
  - mtime = 0, shadow = 0, PRESC = 0, CTRL = 0.
  - every mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
  - prescale counter = 0, rdata = 0, timer_irq = 0.
- Prescaler and counting:
  - When CTRL.en = 1, the prescale counter counts 0..PRESC.
  - A tick fires in the cycle the counter equals PRESC; the counter then returns to 0 and mtime increments by 1 (64-bit wrap from all-ones to 0).
  - PRESC = 0 gives one increment per clk.
  - When CTRL.en = 0, the counter and mtime hold.
- Software writes to mtime:
  - A write to MTIME_LO or MTIME_HI replaces that half only. The other half keeps its pre-write value and does not increment in that cycle.
  - A write that coincides with a tick wins over the tick. The prescale counter resets to 0 in that cycle.
- Writes to PRESC reset the prescale counter to 0.
- Writes to MTIMECMP halves take effect immediately, one half per write. Software must write HI = all-ones first to avoid spurious matches.
- Reads:
  - Latency is 1 cycle. rdata is registered from the register state sampled at the strobe edge.
  - rdata holds its value until the next read strobe.
- Tear-free 64-bit reads: a read of MTIME_LO also captures mtime[63:32] into the shadow in the same edge. A following MTIME_HI read returns the shadow, not live mtime.
- Interrupts: timer_irq[i] is registered each clk as CTRL.ie[i] & (mtime >= mtimecmp[i]), an unsigned 64-bit compare on current register values.
  - The irq rises 1 cycle after the condition becomes true.
  - It stays high while the condition holds, independent of CTRL.en.
  - It clears 1 cycle after software raises mtimecmp above mtime or clears ie[i].
- Simultaneous read and write cannot occur (single strobe).
- Back-to-back strobes are accepted every cycle.
- A reset assertion mid-operation immediately returns all state to reset values; no pending access survives.

Decomposition:
- Shared package/defines:
  - Register offset constants: TMR_MTIME_LO/HI, TMR_PRESC, TMR_CTRL, TMR_CMP_BASE, TMR_CMP_STRIDE.
  - CTRL bit positions.
  - Reset constant for mtimecmp.
- One sub-module: mmio_timer_cmp_ch. It holds one mtimecmp register pair, its write decode and the registered compare/irq flop, and is instantiated NCMP times in a generate loop.

Test Plan:
- Reset then read all registers.
  - Required: MTIME = 0, PRESC = 0, CTRL = 0, MTIMECMP_LO[i]/HI[i] = 32'hFFFFFFFF, timer_irq = 0.
- Write/read mtimecmp (test16 successor): write MTIMECMP_LO[1] = 32'h30303035, read back.
  - Required: rdata = 32'h30303035 one cycle after the strobe; MTIMECMP_HI[1] unchanged at 32'hFFFFFFFF.
- Prescaler: PRESC = 3, CTRL.en = 1, run 40 clk.
  - Required: mtime = 10; increments every 4th cycle.
  - Then write PRESC = 0: mtime increments every cycle thereafter.
- Carry and tear-free read: write MTIME_HI = 0, MTIME_LO = 32'hFFFFFFFE, PRESC = 0, en = 1.
  - After 4 cycles read LO (32'h00000002) then HI; HI returns 1.
  - Repeat with LO read just before the carry; HI returns shadow 0 even though live HI = 1.
- Interrupt: mtime = 0, en = 1, PRESC = 0, MTIMECMP[0] = {0, 20}, ie[0] = 1.
  - Required: timer_irq[0] rises exactly 1 cycle after mtime reaches 20; timer_irq[1] stays 0.
  - Then write MTIMECMP_LO[0] = 1000: irq falls the next cycle.
  - Then clear ie with mtime >= cmp: irq falls next cycle.
- Tick collision and reset: a write to MTIME_LO = 5 in a tick cycle.
  - Required: mtime = 5 afterwards (write wins).
  - Assert reset mid-count: mtime, PRESC and irq = 0 asynchronously, before the next clk edge.
